// File: rtl/vmem_pkg.sv
// Shared types and geometry defaults for the vector memory sequencer.
// Imported by the arbiter and the sequencer top.
package vmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VEC  = 2'd1,
    ST_BYTE = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int LANES             = 16;
  localparam int DEF_IMAGE_WIDTH   = 192;
  localparam int DEF_IMAGE_HEIGHT  = 192;
  localparam int DEF_LANE_STRIDE   = 8;

endpackage

// File: rtl/vmem_rr_arb.sv
// Two-requester round-robin arbiter; requester 0 is the CPU, requester 1 the DMA.
// Grants only while enabled and remembers who won last.
module vmem_rr_arb
  import vmem_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1 = requester 1 won last, so requester 0 goes first out of reset
  logic last_reg;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last_reg ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N)   last_reg <= 1'b1;
    else if (|gnt) last_reg <= gnt[1];
  end

endmodule

// File: rtl/vmem_sequencer.sv
// Sequences 16-lane CPU vector loads/stores and single-byte DMA accesses
// onto a byte-wide single-port memory, one transaction at a time.
module vmem_sequencer
  import vmem_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int LANE_STRIDE  = DEF_LANE_STRIDE
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [15:0]            cpu_addr,
  input  logic [LANES-1:0][15:0] cpu_wd,
  output logic [LANES-1:0][15:0] cpu_rd,
  output logic                   cpu_ack,
  input  logic                   dma_req,
  input  logic                   dma_we,
  input  logic [15:0]            dma_addr,
  input  logic [7:0]             dma_wd,
  output logic [7:0]             dma_rd,
  output logic                   dma_ack,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [15:0]            mem_addr,
  output logic [7:0]             mem_wd,
  input  logic [7:0]             mem_rd,
  output logic                   err
);

  localparam int unsigned MEM_DEPTH = IMAGE_WIDTH * IMAGE_HEIGHT;

  state_t                  state_reg, state_next;
  logic [3:0]              lane_reg;
  logic                    we_reg, dma_sel_reg, err_reg, prev_oor_reg;
  logic [15:0]             addr_reg;
  logic [LANES-1:0][7:0]   wd_reg;
  logic [LANES-2:0][7:0]   load_buf_reg;
  logic [LANES-1:0][7:0]   cpu_rd_reg;
  logic [7:0]              dma_rd_reg;
  logic [1:0]              gnt;
  logic                    arb_en, active, oor, done_load;
  logic [15:0]             access_addr;
  logic [7:0]              cap_byte;
  logic                    unused_wd_hi;

  assign arb_en       = (state_reg == ST_IDLE);
  assign unused_wd_hi = ^cpu_wd;

  vmem_rr_arb u_arb (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en    (arb_en),
    .req   ({dma_req, cpu_req}),
    .gnt   (gnt)
  );

  assign active      = (state_reg == ST_VEC) || (state_reg == ST_BYTE);
  assign access_addr = (state_reg == ST_VEC) ? addr_reg + 16'(int'(lane_reg) * LANE_STRIDE)
                                             : addr_reg;
  assign oor         = 32'(access_addr) >= MEM_DEPTH;

  assign mem_en   = active && !oor;
  assign mem_we   = mem_en && we_reg;
  assign mem_addr = active ? access_addr : 16'h0000;
  assign mem_wd   = mem_we ? wd_reg[lane_reg] : 8'h00;

  // Read data belongs to the previous issue; a skipped lane reads as zero
  assign cap_byte  = prev_oor_reg ? 8'h00 : mem_rd;
  assign done_load = (state_reg == ST_DONE) && !we_reg;

  assign cpu_ack = (state_reg == ST_DONE) && !dma_sel_reg;
  assign dma_ack = (state_reg == ST_DONE) &&  dma_sel_reg;
  assign err     = (state_reg == ST_DONE) &&  err_reg;
  assign dma_rd  = (done_load && dma_sel_reg) ? cap_byte : dma_rd_reg;

  // Load results show up with the ack, then persist from the holding register
  generate
    for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_rd
      assign cpu_rd[gi] = {8'h00, (done_load && !dma_sel_reg) ? load_buf_reg[gi] : cpu_rd_reg[gi]};
    end
  endgenerate
  assign cpu_rd[LANES-1] = {8'h00, (done_load && !dma_sel_reg) ? cap_byte : cpu_rd_reg[LANES-1]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (gnt[0])      state_next = ST_VEC;
        else if (gnt[1]) state_next = ST_BYTE;
      end
      ST_VEC:  if (lane_reg == 4'(LANES - 1)) state_next = ST_DONE;
      ST_BYTE: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg    <= ST_IDLE;
      lane_reg     <= 4'd0;
      we_reg       <= 1'b0;
      dma_sel_reg  <= 1'b0;
      err_reg      <= 1'b0;
      prev_oor_reg <= 1'b0;
      addr_reg     <= 16'h0000;
      wd_reg       <= '0;
      load_buf_reg <= '0;
      cpu_rd_reg   <= '0;
      dma_rd_reg   <= 8'h00;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (|gnt) begin
            dma_sel_reg  <= gnt[1];
            we_reg       <= gnt[1] ? dma_we : cpu_we;
            addr_reg     <= gnt[1] ? dma_addr : cpu_addr;
            lane_reg     <= 4'd0;
            err_reg      <= 1'b0;
            prev_oor_reg <= 1'b0;
            for (int i = 0; i < LANES; i++)
              wd_reg[i] <= gnt[1] ? ((i == 0) ? dma_wd : 8'h00) : cpu_wd[i][7:0];
          end
        end
        ST_VEC: begin
          lane_reg     <= lane_reg + 4'd1;
          prev_oor_reg <= oor;
          err_reg      <= err_reg | oor;
          if (!we_reg && lane_reg != 4'd0)
            load_buf_reg[lane_reg - 4'd1] <= cap_byte;
        end
        ST_BYTE: begin
          prev_oor_reg <= oor;
          err_reg      <= err_reg | oor;
        end
        ST_DONE: begin
          if (!we_reg) begin
            if (dma_sel_reg) dma_rd_reg <= cap_byte;
            else             cpu_rd_reg <= {cap_byte, load_buf_reg};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vmem_sequencer.sv
// Self-checking bench for vmem_sequencer: a byte memory model, a reference
// memory image and a transaction scoreboard drive per-scenario checks.
module tb_vmem_sequencer;

  localparam int DEPTH  = 192 * 192;
  localparam int STRIDE = 8;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0]       cpu_addr, dma_addr;
  logic [15:0][15:0] cpu_wd, cpu_rd;
  logic [7:0]        dma_wd, dma_rd;
  logic              cpu_ack, dma_ack, mem_en, mem_we, err;
  logic [15:0]       mem_addr;
  logic [7:0]        mem_wd, mem_rd;

  always #5 CLK = ~CLK;

  vmem_sequencer dut (
    .CLK(CLK), .RST_N(RST_N),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
    .dma_rd(dma_rd), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .err(err)
  );

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wd;
      else        mem_rd <= mem[mem_addr];
    end
  end

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  typedef struct {
    logic [15:0][15:0] rd;
    logic [7:0]        drd;
    logic              err;
  } txn_t;

  wr_t  wr_obs[$];
  wr_t  wr_exp[$];
  txn_t exp_q[$];
  int   en_cnt = 0, cpu_ack_cnt = 0, dma_ack_cnt = 0;
  int   vectors = 0, miscompares = 0;
  logic [15:0][15:0] exp_cpu_rd;
  logic [7:0]        exp_dma_rd;

  always @(negedge CLK) begin
    if (mem_en) en_cnt++;
    if (mem_en && mem_we) wr_obs.push_back({mem_addr, mem_wd});
    if (cpu_ack) cpu_ack_cnt++;
    if (dma_ack) dma_ack_cnt++;
  end

  // Reference model of one CPU vector transaction
  task automatic start_cpu(input logic we, input logic [15:0] addr, input logic [15:0][15:0] wd);
    txn_t t;
    logic [15:0] a;
    t.err = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a = addr + 16'(i * STRIDE);
      if (int'(a) >= DEPTH) begin
        t.err = 1'b1;
        if (!we) exp_cpu_rd[i] = 16'h0000;
      end else if (we) begin
        ref_mem[a] = wd[i][7:0];
        wr_exp.push_back({a, wd[i][7:0]});
      end else begin
        exp_cpu_rd[i] = {8'h00, ref_mem[a]};
      end
    end
    t.rd = exp_cpu_rd;
    t.drd = exp_dma_rd;
    exp_q.push_back(t);
    cpu_we = we; cpu_addr = addr; cpu_wd = wd; cpu_req = 1'b1;
  endtask

  task automatic start_dma(input logic we, input logic [15:0] addr, input logic [7:0] wd);
    txn_t t;
    t.err = (int'(addr) >= DEPTH);
    if (!t.err && we) begin
      ref_mem[addr] = wd;
      wr_exp.push_back({addr, wd});
    end else if (!we) begin
      exp_dma_rd = t.err ? 8'h00 : ref_mem[addr];
    end
    t.rd = exp_cpu_rd;
    t.drd = exp_dma_rd;
    exp_q.push_back(t);
    dma_we = we; dma_addr = addr; dma_wd = wd; dma_req = 1'b1;
  endtask

  // Waits for the ack, scrambling the granted requester's inputs after grant
  task automatic wait_ack(input bit cpu, output int n, output logic [15:0][15:0] rd,
                          output logic [7:0] drd, output logic e);
    n = -1; rd = '0; drd = '0; e = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        if (cpu) begin
          cpu_addr = 16'($urandom); cpu_we = ~cpu_we;
          for (int i = 0; i < 16; i++) cpu_wd[i] = 16'($urandom);
        end else begin
          dma_addr = 16'($urandom); dma_we = ~dma_we; dma_wd = 8'($urandom);
        end
      end
      if (cpu ? cpu_ack : dma_ack) begin
        n = k; rd = cpu_rd; drd = dma_rd; e = err;
        if (cpu) cpu_req = 1'b0; else dma_req = 1'b0;
        break;
      end
    end
    if (n < 0) begin cpu_req = 1'b0; dma_req = 1'b0; end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; cpu_req = 0; dma_req = 0; cpu_we = 0; dma_we = 0;
    cpu_addr = 0; dma_addr = 0; cpu_wd = '0; dma_wd = 0;
    exp_cpu_rd = '0; exp_dma_rd = 8'h00;
    repeat (2) @(negedge CLK);
    vectors++; if (cpu_ack !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_ack: got %b want 0", cpu_ack); end
    vectors++; if (dma_ack !== 1'b0) begin miscompares++; $display("FAIL reset_dma_ack: got %b want 0", dma_ack); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    vectors++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_en_we: got %b%b want 00", mem_en, mem_we); end
    vectors++; if (mem_addr !== 16'h0 || mem_wd !== 8'h0) begin miscompares++; $display("FAIL reset_mem_addr_wd: got %h/%h want 0000/00", mem_addr, mem_wd); end
    vectors++; if (cpu_rd !== '0) begin miscompares++; $display("FAIL reset_cpu_rd: got %h want 0", cpu_rd); end
    vectors++; if (dma_rd !== 8'h00) begin miscompares++; $display("FAIL reset_dma_rd: got %h want 00", dma_rd); end
    RST_N = 1'b1;
    $display("reset: outputs checked");
  endtask

  task automatic test_vec_load();
    int n; logic [15:0][15:0] rd; logic [7:0] drd; logic e; txn_t t;
    start_cpu(1'b0, 16'h0000, '0);
    wait_ack(1'b1, n, rd, drd, e);
    t = exp_q.pop_front();
    vectors++; if (n !== 17) begin miscompares++; $display("FAIL load_latency: got %0d want 17", n); end
    for (int i = 0; i < 16; i++) begin
      vectors++; if (rd[i] !== t.rd[i]) begin miscompares++; $display("FAIL load_lane%0d: got %h want %h", i, rd[i], t.rd[i]); end
    end
    vectors++; if (e !== t.err) begin miscompares++; $display("FAIL load_err: got %b want %b", e, t.err); end
    @(negedge CLK);
    vectors++; if (cpu_ack !== 1'b0) begin miscompares++; $display("FAIL load_ack_pulse: got %b want 0", cpu_ack); end
    $display("vec load 0x0000: ack after %0d cycles, lane1=%h", n, rd[1]);
  endtask

  task automatic test_vec_store();
    int n; logic [15:0][15:0] rd, wd; logic [7:0] drd; logic e; txn_t t; wr_t o, x;
    for (int i = 0; i < 16; i++) wd[i] = {8'h5A, 8'(i + 1)};
    start_cpu(1'b1, 16'h0010, wd);
    wait_ack(1'b1, n, rd, drd, e);
    t = exp_q.pop_front();
    vectors++; if (n !== 17) begin miscompares++; $display("FAIL store_latency: got %0d want 17", n); end
    vectors++; if (e !== t.err) begin miscompares++; $display("FAIL store_err: got %b want %b", e, t.err); end
    vectors++; if (rd !== t.rd) begin miscompares++; $display("FAIL store_cpu_rd_held: got %h want %h", rd, t.rd); end
    vectors++; if (wr_obs.size() !== wr_exp.size()) begin miscompares++; $display("FAIL store_write_count: got %0d want %0d", wr_obs.size(), wr_exp.size()); end
    while (wr_obs.size() > 0 && wr_exp.size() > 0) begin
      o = wr_obs.pop_front(); x = wr_exp.pop_front();
      vectors++; if (o !== x) begin miscompares++; $display("FAIL store_write: got %h:%h want %h:%h", o.a, o.d, x.a, x.d); end
    end
    wr_obs.delete(); wr_exp.delete();
    @(negedge CLK);
    $display("vec store 0x0010: ack after %0d cycles, err=%b", n, e);
  endtask

  task automatic test_dma_read();
    int n; logic [15:0][15:0] rd; logic [7:0] drd; logic e; txn_t t;
    start_dma(1'b0, 16'h0005, 8'h00);
    @(negedge CLK);
    vectors++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0005) begin
      miscompares++; $display("FAIL dma_issue: got en=%b we=%b addr=%h want 1/0/0005", mem_en, mem_we, mem_addr); end
    wait_ack(1'b0, n, rd, drd, e);
    t = exp_q.pop_front();
    // one cycle after issue is the ack cycle, i.e. t+2 from the grant edge
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL dma_latency: got %0d want 1", n); end
    vectors++; if (drd !== t.drd) begin miscompares++; $display("FAIL dma_rd: got %h want %h", drd, t.drd); end
    vectors++; if (e !== t.err) begin miscompares++; $display("FAIL dma_err: got %b want %b", e, t.err); end
    @(negedge CLK);
    vectors++; if (dma_ack !== 1'b0 || dma_rd !== t.drd) begin miscompares++; $display("FAIL dma_after_ack: got ack=%b rd=%h want 0/%h", dma_ack, dma_rd, t.drd); end
    $display("dma read 0x0005: rd=%h", drd);
  endtask

  task automatic test_dma_write();
    int n; logic [15:0][15:0] rd; logic [7:0] drd; logic e; txn_t t; wr_t o, x;
    start_dma(1'b1, 16'h0123, 8'h3C);
    wait_ack(1'b0, n, rd, drd, e);
    t = exp_q.pop_front();
    vectors++; if (n !== 2) begin miscompares++; $display("FAIL dmaw_latency: got %0d want 2", n); end
    vectors++; if (drd !== t.drd) begin miscompares++; $display("FAIL dmaw_rd_held: got %h want %h", drd, t.drd); end
    vectors++; if (wr_obs.size() !== 1) begin miscompares++; $display("FAIL dmaw_count: got %0d want 1", wr_obs.size()); end
    if (wr_obs.size() > 0 && wr_exp.size() > 0) begin
      o = wr_obs.pop_front(); x = wr_exp.pop_front();
      vectors++; if (o !== x) begin miscompares++; $display("FAIL dmaw_write: got %h:%h want %h:%h", o.a, o.d, x.a, x.d); end
    end
    wr_obs.delete(); wr_exp.delete();
    @(negedge CLK);
    start_dma(1'b0, 16'h0123, 8'h00);
    wait_ack(1'b0, n, rd, drd, e);
    t = exp_q.pop_front();
    vectors++; if (drd !== t.drd) begin miscompares++; $display("FAIL dmaw_readback: got %h want %h", drd, t.drd); end
    @(negedge CLK);
    $display("dma write/read 0x0123: rd=%h", drd);
  endtask

  task automatic test_oor_load();
    int n; logic [15:0][15:0] rd; logic [7:0] drd; logic e; txn_t t;
    en_cnt = 0;
    start_cpu(1'b0, 16'h8FF0, '0);
    wait_ack(1'b1, n, rd, drd, e);
    t = exp_q.pop_front();
    vectors++; if (n !== 17) begin miscompares++; $display("FAIL oor_latency: got %0d want 17", n); end
    vectors++; if (e !== 1'b1 || t.err !== 1'b1) begin miscompares++; $display("FAIL oor_err: got %b want 1", e); end
    vectors++; if (en_cnt !== 2) begin miscompares++; $display("FAIL oor_issue_count: got %0d want 2", en_cnt); end
    for (int i = 0; i < 16; i++) begin
      vectors++; if (rd[i] !== t.rd[i]) begin miscompares++; $display("FAIL oor_lane%0d: got %h want %h", i, rd[i], t.rd[i]); end
    end
    @(negedge CLK);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL oor_err_pulse: got %b want 0", err); end
    $display("oor load 0x8FF0: %0d issues, err=%b", en_cnt, e);
  endtask

  task automatic test_drop();
    int n = -1; int dma_before; logic [15:0][15:0] wd; txn_t t; wr_t o, x;
    for (int i = 0; i < 16; i++) wd[i] = 16'(i * 3 + 7);
    dma_before = dma_ack_cnt;
    start_cpu(1'b1, 16'h0400, wd);
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      if (k == 3) begin dma_we = 1'b1; dma_addr = 16'h0077; dma_wd = 8'hEE; dma_req = 1'b1; end
      if (k == 6) dma_req = 1'b0;
      if (cpu_ack) begin n = k; cpu_req = 1'b0; break; end
    end
    t = exp_q.pop_front();
    repeat (3) @(negedge CLK);
    vectors++; if (n !== 17) begin miscompares++; $display("FAIL drop_cpu_latency: got %0d want 17", n); end
    vectors++; if (dma_ack_cnt !== dma_before) begin miscompares++; $display("FAIL drop_dma_ack: got %0d want %0d", dma_ack_cnt - dma_before, 0); end
    vectors++; if (wr_obs.size() !== wr_exp.size()) begin miscompares++; $display("FAIL drop_write_count: got %0d want %0d", wr_obs.size(), wr_exp.size()); end
    while (wr_obs.size() > 0 && wr_exp.size() > 0) begin
      o = wr_obs.pop_front(); x = wr_exp.pop_front();
      vectors++; if (o !== x) begin miscompares++; $display("FAIL drop_write: got %h:%h want %h:%h", o.a, o.d, x.a, x.d); end
    end
    wr_obs.delete(); wr_exp.delete();
    $display("dropped dma request: cpu ack at %0d, dma acks %0d", n, dma_ack_cnt - dma_before);
  endtask

  task automatic test_back_to_back();
    int acks = 0; int exp_k[$]; txn_t t;
    exp_k.push_back(17); exp_k.push_back(35);
    start_cpu(1'b0, 16'h0000, '0);
    start_cpu(1'b0, 16'h0000, '0);
    for (int k = 1; k <= 60 && acks < 2; k++) begin
      @(negedge CLK);
      if (cpu_ack) begin
        t = exp_q.pop_front();
        vectors++; if (k !== exp_k[acks]) begin miscompares++; $display("FAIL b2b_ack%0d_cycle: got %0d want %0d", acks, k, exp_k[acks]); end
        vectors++; if (cpu_rd !== t.rd) begin miscompares++; $display("FAIL b2b_rd%0d: got %h want %h", acks, cpu_rd, t.rd); end
        acks++;
        if (acks == 2) cpu_req = 1'b0;
      end
    end
    vectors++; if (acks !== 2) begin miscompares++; $display("FAIL b2b_acks: got %0d want 2", acks); cpu_req = 1'b0; end
    exp_q.delete();
    @(negedge CLK);
    $display("back-to-back loads: %0d acks", acks);
  endtask

  task automatic test_round_robin();
    int acks = 0; int quiet = 0; logic prev = 1'b0; logic who; logic exp_who[$];
    RST_N = 1'b0; repeat (2) @(negedge CLK); RST_N = 1'b1;
    exp_who.push_back(1'b1); exp_who.push_back(1'b0); exp_who.push_back(1'b1);
    cpu_we = 0; cpu_addr = 16'h0000; dma_we = 0; dma_addr = 16'h0005;
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int k = 0; k < 200 && acks < 3; k++) begin
      @(negedge CLK);
      if (cpu_ack || dma_ack) begin
        who = cpu_ack;
        vectors++; if (cpu_ack && dma_ack) begin miscompares++; $display("FAIL rr_dual_ack: got both want one"); end
        vectors++; if (prev !== 1'b0) begin miscompares++; $display("FAIL rr_pulse: ack high %0d cycles want 1", 2); end
        vectors++; if (who !== exp_who[acks]) begin miscompares++; $display("FAIL rr_order%0d: got cpu=%b want cpu=%b", acks, who, exp_who[acks]); end
        $display("round robin ack %0d: %s", acks, who ? "cpu" : "dma");
        acks++;
        if (acks == 3) begin cpu_req = 1'b0; dma_req = 1'b0; end
      end
      prev = cpu_ack | dma_ack;
    end
    vectors++; if (acks !== 3) begin miscompares++; $display("FAIL rr_acks: got %0d want 3", acks); cpu_req = 0; dma_req = 0; end
    repeat (5) begin @(negedge CLK); if (cpu_ack || dma_ack) quiet++; end
    vectors++; if (quiet !== 0) begin miscompares++; $display("FAIL rr_extra_ack: got %0d want 0", quiet); end
  endtask

  task automatic test_reset_mid();
    int n; int cpu_before; logic [15:0][15:0] rd, wd; logic [7:0] drd; logic e; txn_t t; wr_t o, x;
    wr_obs.delete(); wr_exp.delete();
    for (int i = 0; i < 16; i++) wd[i] = 16'(8'hA0 + i);
    cpu_before = cpu_ack_cnt;
    cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wd = wd; cpu_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ref_mem[16'h0200 + 16'(i * STRIDE)] = wd[i][7:0];
      wr_exp.push_back({16'h0200 + 16'(i * STRIDE), wd[i][7:0]});
    end
    repeat (7) @(negedge CLK);
    RST_N = 1'b0; cpu_req = 1'b0;
    @(negedge CLK);
    vectors++; if (cpu_ack !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL midrst_ack_err: got %b/%b want 0/0", cpu_ack, err); end
    vectors++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_wd !== 8'h0) begin
      miscompares++; $display("FAIL midrst_mem: got %b %b %h %h want 0 0 0000 00", mem_en, mem_we, mem_addr, mem_wd); end
    vectors++; if (cpu_rd !== '0 || dma_rd !== 8'h00) begin miscompares++; $display("FAIL midrst_rd: got %h/%h want 0/00", cpu_rd, dma_rd); end
    vectors++; if (cpu_ack_cnt !== cpu_before) begin miscompares++; $display("FAIL midrst_no_ack: got %0d acks want 0", cpu_ack_cnt - cpu_before); end
    vectors++; if (wr_obs.size() !== 7) begin miscompares++; $display("FAIL midrst_write_count: got %0d want 7", wr_obs.size()); end
    while (wr_obs.size() > 0 && wr_exp.size() > 0) begin
      o = wr_obs.pop_front(); x = wr_exp.pop_front();
      vectors++; if (o !== x) begin miscompares++; $display("FAIL midrst_write: got %h:%h want %h:%h", o.a, o.d, x.a, x.d); end
    end
    wr_obs.delete(); wr_exp.delete();
    exp_cpu_rd = '0; exp_dma_rd = 8'h00;
    RST_N = 1'b1;
    start_cpu(1'b1, 16'h0200, wd);
    wait_ack(1'b1, n, rd, drd, e);
    t = exp_q.pop_front();
    vectors++; if (n !== 17 || e !== t.err) begin miscompares++; $display("FAIL midrst_reissue: got n=%0d err=%b want 17/%b", n, e, t.err); end
    vectors++; if (wr_obs.size() !== 16) begin miscompares++; $display("FAIL midrst_reissue_count: got %0d want 16", wr_obs.size()); end
    while (wr_obs.size() > 0 && wr_exp.size() > 0) begin
      o = wr_obs.pop_front(); x = wr_exp.pop_front();
      vectors++; if (o !== x) begin miscompares++; $display("FAIL midrst_reissue_write: got %h:%h want %h:%h", o.a, o.d, x.a, x.d); end
    end
    wr_obs.delete(); wr_exp.delete();
    @(negedge CLK);
    $display("reset mid-store: reissued store acked after %0d cycles", n);
  endtask

  initial begin
    mem_rd = 8'h00;
    for (int a = 0; a < 65536; a++) begin mem[a] = 8'(a); ref_mem[a] = 8'(a); end
    @(negedge CLK);
    test_reset();
    test_vec_load();
    test_vec_store();
    test_dma_read();
    test_dma_write();
    test_oor_load();
    test_drop();
    test_back_to_back();
    test_round_robin();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
